// File: rtl/hrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hrt_pkg
// Description : Shared definitions for the high-resolution timer master
//               sequencer: timer slave register word addresses, control
//               register bit positions, default control words and the
//               sequencer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package hrt_pkg;

  // Timer slave register word addresses.
  localparam logic [2:0] REG_STATUS   = 3'd0;  // any write clears timeout
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;  // write latches counter snapshot
  localparam logic [2:0] REG_SNAP_H   = 3'd5;

  // Control register bit positions.
  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  // Default control words: run = START|CONT|ITO, stop = STOP only.
  localparam logic [15:0] CTRL_RUN_DEFAULT =
    16'((1 << CTRL_START_BIT) | (1 << CTRL_CONT_BIT) | (1 << CTRL_ITO_BIT));
  localparam logic [15:0] CTRL_STOP_DEFAULT = 16'(1 << CTRL_STOP_BIT);

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WR_PL        = 4'd1,
    ST_WR_PH        = 4'd2,
    ST_WR_CTRL_RUN  = 4'd3,
    ST_RUN          = 4'd4,
    ST_CLR_STATUS   = 4'd5,
    ST_SNAP_WR      = 4'd6,
    ST_SNAP_RD_L    = 4'd7,
    ST_SNAP_CAP_L   = 4'd8,
    ST_SNAP_CAP_H   = 4'd9,
    ST_WR_CTRL_STOP = 4'd10
  } state_e;

  // Busy covers every transient bus-sequencing state.
  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_RUN);
  endfunction

endpackage : hrt_pkg
`default_nettype wire

// File: rtl/hrt_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hrt_master_sequencer
// Description : Bus master that programs and services a timer slave over a
//               simple fixed-latency memory-mapped port. It writes the period
//               and run control word on start, clears the status register on
//               every timeout interrupt (counting them), reads a two-word
//               counter snapshot on request and writes the stop control word
//               on stop.
// Ports       : clk, reset_n         - clock, asynchronous active-low reset
//               cfg_period/start/stop- period value, start and stop pulses
//               snap_req             - snapshot request pulse
//               timer_irq            - level timeout interrupt from the slave
//               avm_*                - master port (3-bit word address,
//                                      16-bit data, read latency 1)
//               tick_count           - serviced timeout count
//               snap_value/snap_valid- last snapshot and its update pulse
//               running, busy        - timer active / bus sequence active
// Revision    : 1.0 - initial release
// ============================================================================
module hrt_master_sequencer
  import hrt_pkg::*;
#(
  parameter logic [15:0] CTRL_RUN_WORD  = CTRL_RUN_DEFAULT,
  parameter logic [15:0] CTRL_STOP_WORD = CTRL_STOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        snap_req,
  input  logic        timer_irq,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic [31:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic        running,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        stop_pend_q, stop_pend_d;
  logic        snap_pend_q, snap_pend_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_valid_q, snap_valid_d;
  logic        running_q, running_d;

  // --------------------------------------------------------------------------
  // State and data registers. Bus outputs are decoded from state_q, so an
  // asynchronous reset drops chipselect in the same instant it asserts.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      period_q     <= 32'd0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      tick_count_q <= 32'd0;
      snap_lo_q    <= 16'd0;
      snap_value_q <= 32'd0;
      snap_valid_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      stop_pend_q  <= stop_pend_d;
      snap_pend_q  <= snap_pend_d;
      tick_count_q <= tick_count_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      running_q    <= running_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and bus decode.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    tick_count_d   = tick_count_q;
    snap_lo_d      = snap_lo_q;
    snap_value_d   = snap_value_q;
    snap_valid_d   = 1'b0;
    running_d      = running_q;

    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'd0;

    // Requests arriving outside IDLE are remembered until RUN can act on
    // them; in IDLE there is nothing to stop or snapshot.
    stop_pend_d = stop_pend_q | (cfg_stop & (state_q != ST_IDLE));
    snap_pend_d = snap_pend_q | (snap_req & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          period_d = cfg_period;
          state_d  = ST_WR_PL;
        end
      end

      ST_WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIOD_L;
        avm_writedata  = period_q[15:0];
        state_d        = ST_WR_PH;
      end

      ST_WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIOD_H;
        avm_writedata  = period_q[31:16];
        state_d        = ST_WR_CTRL_RUN;
      end

      ST_WR_CTRL_RUN: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_RUN_WORD;
        running_d      = 1'b1;
        state_d        = ST_RUN;
      end

      ST_RUN: begin
        // A pending timeout is serviced before a stop so no tick is lost;
        // stop outranks snapshot so a stop never waits behind a read.
        if (timer_irq) begin
          state_d = ST_CLR_STATUS;
        end else if (stop_pend_q) begin
          state_d = ST_WR_CTRL_STOP;
        end else if (snap_pend_q) begin
          // A fresh request in this very cycle re-arms the flag.
          snap_pend_d = snap_req;
          state_d     = ST_SNAP_WR;
        end
      end

      ST_CLR_STATUS: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
        avm_writedata  = 16'd0;
        tick_count_d   = tick_count_q + 32'd1;
        state_d        = ST_RUN;
      end

      ST_SNAP_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_SNAP_L;
        avm_writedata  = 16'd0;
        state_d        = ST_SNAP_RD_L;
      end

      ST_SNAP_RD_L: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_SNAP_L;
        state_d        = ST_SNAP_CAP_L;
      end

      // Read data trails the address by one cycle, so the low half arrives
      // while the high-half read is being issued.
      ST_SNAP_CAP_L: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_SNAP_H;
        snap_lo_d      = avm_readdata;
        state_d        = ST_SNAP_CAP_H;
      end

      ST_SNAP_CAP_H: begin
        snap_value_d = {avm_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = ST_RUN;
      end

      ST_WR_CTRL_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = CTRL_STOP_WORD;
        running_d      = 1'b0;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Whatever was still pending is meaningless once the timer is idle.
    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
      snap_pend_d = 1'b0;
    end
  end

  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
  assign running    = running_q;
  assign busy       = is_busy(state_q);

endmodule : hrt_master_sequencer
`default_nettype wire

// File: tb/tb_hrt_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hrt_master_sequencer
// Description : Self-checking bench for hrt_master_sequencer. Stimulus tasks
//               push expected bus transactions and snapshot values into
//               queues from a transaction-level model; an independent monitor
//               pops and compares whenever the DUT drives the bus or pulses
//               snap_valid. A small slave model supplies read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hrt_master_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        snap_req = 1'b0;
  logic        timer_irq = 1'b0;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic [31:0] tick_count;
  logic [31:0] snap_value;
  logic        snap_valid;
  logic        running;
  logic        busy;

  always #5 clk = ~clk;

  hrt_master_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_period    (cfg_period),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .snap_req      (snap_req),
    .timer_irq     (timer_irq),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .tick_count    (tick_count),
    .snap_value    (snap_value),
    .snap_valid    (snap_valid),
    .running       (running),
    .busy          (busy)
  );

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_snap[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_tick = 32'd0;
  bit          m_running = 1'b0;
  logic [31:0] snap_next = 32'd0;
  logic [31:0] snap_shadow = 32'd0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    exp_bus.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic push_r(input logic [2:0] a);
    exp_bus.push_back('{wr: 1'b0, addr: a, data: 16'd0});
  endtask

  // Timer slave: snapshot latched by a write to word 4, read data returned
  // one cycle after the read address; garbage otherwise.
  initial begin : slave
    logic       rd;
    logic [2:0] ra;
    avm_readdata = 16'd0;
    forever begin
      @(negedge clk);
      rd = avm_chipselect && avm_write_n;
      ra = avm_address;
      if (avm_chipselect && !avm_write_n && avm_address == 3'd4)
        snap_shadow = snap_next;
      @(posedge clk);
      #1;
      if (rd && ra == 3'd4)      avm_readdata = snap_shadow[15:0];
      else if (rd && ra == 3'd5) avm_readdata = snap_shadow[31:16];
      else                       avm_readdata = 16'($urandom);
    end
  end

  // Monitor: every bus cycle and every snap_valid pulse is checked in order.
  initial begin : monitor
    bus_t        e;
    logic [31:0] s;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (avm_chipselect) begin
          if (exp_bus.size() == 0) begin
            chk(1'b0, "bus_unexpected",
                {12'd0, !avm_write_n, avm_address, avm_writedata}, 32'd0);
          end else begin
            e = exp_bus.pop_front();
            chk((!avm_write_n) == e.wr && avm_address == e.addr &&
                (!e.wr || avm_writedata == e.data), "bus_txn",
                {12'd0, !avm_write_n, avm_address, avm_writedata},
                {12'd0, e.wr, e.addr, e.data});
          end
        end else begin
          chk(avm_write_n && avm_address == 3'd0 && avm_writedata == 16'd0,
              "bus_idle", {12'd0, avm_write_n, avm_address, avm_writedata},
              {12'd0, 1'b1, 3'd0, 16'd0});
        end
        if (snap_valid) begin
          if (exp_snap.size() == 0) begin
            chk(1'b0, "snap_unexpected", snap_value, 32'd0);
          end else begin
            s = exp_snap.pop_front();
            chk(snap_value == s, "snap_value", snap_value, s);
          end
        end
      end
    end
  end

  // One cycle; the slave drops its interrupt when it sees the status clear.
  task automatic step();
    @(negedge clk);
    if (timer_irq && avm_chipselect && !avm_write_n && avm_address == 3'd0)
      timer_irq = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      step();
      if (exp_bus.size() == 0 && exp_snap.size() == 0 && !busy && !timer_irq)
        done = 1'b1;
    end
    if (!done) begin
      chk(1'b0, name, 32'(exp_bus.size()), 32'd0);
      exp_bus.delete();
      exp_snap.delete();
      timer_irq = 1'b0;
    end
    repeat (3) step();
    chk(tick_count == m_tick, "tick_count", tick_count, m_tick);
    chk(running == m_running, "running", 32'(running), 32'(m_running));
    chk(busy == 1'b0, "busy_idle", 32'(busy), 32'd0);
  endtask

  // Transaction-level model: start from idle programs the timer; pulses that
  // coincide with idle are dropped; once running, a timeout is serviced
  // first, then stop (which discards a snapshot request) or snapshot.
  task automatic issue(input bit st, input bit sp, input bit sn, input bit iq,
                       input bit late, input logic [31:0] p);
    bit eff_sp = sp;
    bit eff_sn = sn;
    bit eff_iq = iq;
    bit late_eff = 1'b0;
    snap_next = $urandom;
    if (!m_running) begin
      if (st) begin
        push_w(3'd2, p[15:0]);
        push_w(3'd3, p[31:16]);
        push_w(3'd1, 16'h0007);
        m_running = 1'b1;
        late_eff  = late;
        if (!late) begin
          eff_sp = 1'b0;
          eff_sn = 1'b0;
        end
      end else begin
        eff_sp = 1'b0;
        eff_sn = 1'b0;
        eff_iq = 1'b0;
      end
    end
    if (m_running) begin
      if (eff_iq) begin
        push_w(3'd0, 16'h0000);
        m_tick = m_tick + 32'd1;
      end
      if (eff_sp) begin
        push_w(3'd1, 16'h0008);
        m_running = 1'b0;
      end else if (eff_sn) begin
        push_w(3'd4, 16'h0000);
        push_r(3'd4);
        push_r(3'd5);
        exp_snap.push_back(snap_next);
      end
    end
    cfg_period = p;
    cfg_start  = st;
    if (!late_eff) begin
      cfg_stop = sp;
      snap_req = sn;
      if (eff_iq) timer_irq = 1'b1;
    end
    step();
    cfg_start  = 1'b0;
    cfg_period = $urandom;
    if (late_eff) begin
      cfg_stop = sp;
      snap_req = sn;
      if (eff_iq) timer_irq = 1'b1;
      step();
    end
    cfg_stop = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(!avm_chipselect && avm_write_n && avm_address == 3'd0 &&
        avm_writedata == 16'd0, {name, "_bus"},
        {12'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
        {12'd0, 1'b0, 1'b1, 3'd0, 16'd0});
    chk(tick_count == 32'd0, {name, "_tick"}, tick_count, 32'd0);
    chk(snap_value == 32'd0, {name, "_snap_value"}, snap_value, 32'd0);
    chk({snap_valid, running, busy} == 3'b000, {name, "_flags"},
        32'({snap_valid, running, busy}), 32'd0);
  endtask

  initial begin : stimulus
    bit found;
    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) step();

    // Stop and snapshot in IDLE are ignored.
    issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain("drain_idle_ignore");

    // Start: three consecutive writes, running rises after the control write.
    push_w(3'd2, 16'h86A0);
    push_w(3'd3, 16'h0001);
    push_w(3'd1, 16'h0007);
    cfg_period = 32'h0001_86A0;
    cfg_start  = 1'b1;
    step();
    cfg_start = 1'b0;
    chk(avm_chipselect && !avm_write_n, "start_wr1", 32'(avm_chipselect), 32'd1);
    step();
    chk(avm_chipselect && !avm_write_n, "start_wr2", 32'(avm_chipselect), 32'd1);
    step();
    chk(avm_chipselect && !avm_write_n && !running, "start_wr3",
        32'({avm_chipselect, running}), 32'b10);
    step();
    chk(running && !avm_chipselect, "start_running",
        32'({running, avm_chipselect}), 32'b10);
    m_running = 1'b1;
    drain("drain_start");

    // Single timeout: one status clear, tick 0 -> 1.
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drain("drain_irq");

    // Snapshot with known counter value.
    push_w(3'd4, 16'h0000);
    push_r(3'd4);
    push_r(3'd5);
    exp_snap.push_back(32'h0000_1234);
    snap_next = 32'h0000_1234;
    snap_req  = 1'b1;
    step();
    snap_req = 1'b0;
    drain("drain_snap");

    // Stop and timeout together: clear first, then stop.
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    drain("drain_stop_irq");

    // Randomized operation mix.
    for (int k = 0; k < 60; k++) begin
      issue(($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1) == 1, $urandom);
      drain("drain_random");
    end

    // Counter wrap.
    if (!m_running) begin
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
      drain("drain_wrap_start");
    end
    force dut.tick_count_q = 32'hFFFF_FFFE;
    step();
    release dut.tick_count_q;
    m_tick = 32'hFFFF_FFFE;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drain("drain_wrap1");
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drain("drain_wrap2");

    // Reset during the high-half read of a snapshot.
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (avm_chipselect && avm_write_n && avm_address == 3'd5) found = 1'b1;
    end
    chk(found, "snap_cap_l_reached", 32'(found), 32'd1);
    reset_n = 1'b0;
    exp_bus.delete();
    exp_snap.delete();
    #1;
    chk_reset_outputs("midsnap_reset");
    for (int i = 0; i < 3; i++) begin
      step();
      chk(!avm_chipselect && !snap_valid, "midsnap_quiet",
          32'({avm_chipselect, snap_valid}), 32'd0);
    end
    reset_n   = 1'b1;
    m_tick    = 32'd0;
    m_running = 1'b0;
    drain("drain_after_reset");

    // Recovery after reset.
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, $urandom);
    drain("drain_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hrt_master_sequencer
`default_nettype wire

// File: doc/hrt_master_sequencer.md
HRT_MASTER_SEQUENCER -- requirements
Module: hrt_master_sequencer

Interface
REQ-001 SHALL have parameter CTRL_RUN_WORD, default 16'h0007, control word written at start (START|CONT|ITO).
REQ-002 SHALL have parameter CTRL_STOP_WORD, default 16'h0008, control word written at stop (STOP, CONT=0, ITO=0).
REQ-003 clk  in  1  clock, all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_period  in  32  timer period, sampled on accepted start.
REQ-006 cfg_start  in  1  one-cycle pulse: program period and start timer.
REQ-007 cfg_stop  in  1  one-cycle pulse: stop timer.
REQ-008 snap_req  in  1  one-cycle pulse: capture and read counter snapshot.
REQ-009 timer_irq  in  1  level interrupt from timer slave.
REQ-010 avm_address  out  3  timer register word address.
REQ-011 avm_chipselect  out  1  bus access strobe.
REQ-012 avm_write_n  out  1  active-low write.
REQ-013 avm_writedata  out  16  write data.
REQ-014 avm_readdata  in  16  read data, valid the cycle after address is driven (fixed latency 1, no waitrequest).
REQ-015 tick_count  out  32  number of serviced timeouts.
REQ-016 snap_value  out  32  last snapshot {high,low}; snap_valid  out  1  one-cycle pulse when snap_value updates.
REQ-017 running  out  1  timer started and not stopped; busy  out  1  high in any state other than IDLE and RUN.

Function
REQ-018 Register map SHALL be: 0 status (write clears timeout), 1 control, 2 period low, 3 period high, 4 snap low, 5 snap high.
REQ-019 Each write SHALL be one cycle: chipselect=1, write_n=0, address/writedata valid; reads: chipselect=1, write_n=1; idle cycles: chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 States SHALL be IDLE, WR_PL, WR_PH, WR_CTRL_RUN, RUN, CLR_STATUS, SNAP_WR, SNAP_RD_L, SNAP_CAP_L, SNAP_CAP_H, WR_CTRL_STOP.
REQ-021 IDLE + cfg_start: latch cfg_period, go WR_PL (write addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTRL_RUN (addr 1, CTRL_RUN_WORD) -> RUN; running=1 from edge ending WR_CTRL_RUN.
REQ-022 cfg_start outside IDLE SHALL be ignored; cfg_stop and snap_req in IDLE SHALL be ignored.
REQ-023 cfg_stop in any non-IDLE state SHALL set stop_pend; snap_req in RUN or busy states after start SHALL set snap_pend; pending flags cleared when serviced.
REQ-024 RUN priority per cycle: timer_irq -> CLR_STATUS; else stop_pend -> WR_CTRL_STOP; else snap_pend -> SNAP_WR; else stay.
REQ-025 CLR_STATUS: write addr 0, data 0; tick_count += 1 (wraps 32'hFFFF_FFFF -> 0); return RUN.
REQ-026 Snapshot: SNAP_WR writes addr 4 (data 0); SNAP_RD_L reads addr 4; SNAP_CAP_L reads addr 5 and captures readdata as low half; SNAP_CAP_H chipselect=0, captures high half, updates snap_value, pulses snap_valid next cycle; return RUN.
REQ-027 WR_CTRL_STOP: write addr 1, CTRL_STOP_WORD; running=0; go IDLE; tick_count retained.
REQ-028 timer_irq outside RUN SHALL not be lost: it remains level-asserted and is serviced on RUN entry.
REQ-029 Simultaneous cfg_stop and snap_req SHALL service stop first; snap_pend cleared on IDLE entry.

Reset
REQ-030 On reset_n=0: state IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, tick_count=0, snap_value=0, snap_valid=0, running=0, busy=0, pending flags 0.
REQ-031 Reset mid-transaction SHALL abort immediately with no further bus access.

Structure
REQ-032 Package hrt_pkg SHALL hold register address constants, control bit positions (ITO=0, CONT=1, START=2, STOP=3) and the state enum.
REQ-033 Single module; no sub-module required.

Verification
REQ-034 cfg_period=32'h0001_86A0, cfg_start -> writes (2,16'h86A0),(3,16'h0001),(1,16'h0007) on 3 consecutive cycles, running=1.
REQ-035 timer_irq held high in RUN -> one write (0,16'h0000), tick_count 0->1, irq drop -> no second increment.
REQ-036 snap_req with slave readdata 16'h1234 then 16'h0000 -> write addr 4, reads 4,5, snap_value=32'h0000_1234, snap_valid one cycle.
REQ-037 cfg_stop and timer_irq same cycle in RUN -> status clear first, then write (1,16'h0008), running=0, state IDLE.
REQ-038 tick_count preset path to 32'hFFFF_FFFF via repeated irq -> next irq wraps to 0.
REQ-039 reset_n low during SNAP_CAP_L -> chipselect=0 next cycle, snap_valid never pulses, all outputs at reset values.
